sm4_engine_p: RTL

- Parametrised SM4 (GB/T 32907) block cipher engine; successor to the fixed 1-bit serial SM4 datapath.
- Configurable I/O beat width and S-box parallelism.
- Supports encrypt and decrypt via a stored round-key file.
- Uses valid/ready handshakes on key, data-in and data-out, so it drops into streaming fabric without an external sequencer.

---
 rtl/sm4_engine_p.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sm4_engine_p.sv
// SM4 block cipher engine with IO_W-bit valid/ready beats and SBOX_PAR S-box lanes.
// Latency: last din beat to first dout_valid is 32*(4/SBOX_PAR+1)+1 cycles; key expansion takes 32*(4/SBOX_PAR+1).
module sm4_engine_p #(
    parameter int IO_W     = 8,
    parameter int SBOX_PAR = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    output logic            key_ready,
    input  logic [IO_W-1:0] key_in,
    output logic            key_ok,
    input  logic            mode,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [IO_W-1:0] din,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [IO_W-1:0] dout,
    output logic            busy
);
    localparam int NB = 128 / IO_W;
    localparam int SC = 4 / SBOX_PAR;
    localparam logic [7:0]   LAST_BEAT = 8'(NB - 1);
    localparam logic [2:0]   UPD_SUB   = 3'(SC);
    localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
    localparam logic [2047:0] SBOX_TBL = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    typedef enum logic [2:0] {IDLE, KLOAD, KEXP, READY, DLOAD, ROUND, UNLOAD} state_t;
    state_t state, state_nxt;

    logic [127:0] blk, blk_sh;
    logic [31:0]  tau, arg, lin, ck, rk_word;
    logic [31:0]  x0, x1, x2, x3;
    logic [31:0]  rk [32];
    logic [7:0]   beat, beat_nxt;
    logic [4:0]   rnd;
    logic [2:0]   sub;
    logic [1:0]   lane_base;
    logic [7:0]   lane_out [SBOX_PAR];
    logic         fin, dec, last_beat, key_fire, din_fire, dout_fire;

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TBL[2047 - 8*int'(a) -: 8];
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [7:0] ck_byte(input logic [4:0] r, input logic [1:0] j);
        logic [7:0] n;
        n = {1'b0, r, j};
        return n * 8'd7;
    endfunction

    assign {x0, x1, x2, x3} = blk;
    assign ck        = {ck_byte(rnd, 2'd0), ck_byte(rnd, 2'd1), ck_byte(rnd, 2'd2), ck_byte(rnd, 2'd3)};
    assign rk_word   = rk[dec ? ~rnd : rnd];
    assign arg       = x1 ^ x2 ^ x3 ^ ((state == KEXP) ? ck : rk_word);
    assign lin       = (state == KEXP) ? (tau ^ rol(tau, 13) ^ rol(tau, 23))
                                       : (tau ^ rol(tau, 2) ^ rol(tau, 10) ^ rol(tau, 18) ^ rol(tau, 24));
    assign lane_base = 2'((int'(sub) % SC) * SBOX_PAR);
    assign last_beat = (beat == LAST_BEAT);
    assign beat_nxt  = last_beat ? 8'd0 : beat + 8'd1;
    assign key_fire  = key_valid & key_ready;
    assign din_fire  = din_valid & din_ready;
    assign dout_fire = dout_valid & dout_ready;
    assign busy      = (state != IDLE) && (state != READY);
    assign dout      = (state == UNLOAD) ? blk[127 -: IO_W] : '0;

    // One shared S-box bank serves both key expansion and data rounds.
    for (genvar l = 0; l < SBOX_PAR; l++) begin : g_lane
        assign lane_out[l] = sbox(arg[8*(3 - (int'(lane_base) + l)) +: 8]);
    end

    if (IO_W == 128) begin : g_sh
        assign blk_sh = '0;
    end else begin : g_sh
        assign blk_sh = {blk[127-IO_W:0], {IO_W{1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        key_ready  = 1'b0;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = (NB == 1) ? KEXP : KLOAD;
            end
            KLOAD: begin
                key_ready = 1'b1;
                if (key_valid && last_beat) state_nxt = KEXP;
            end
            KEXP: if (sub == UPD_SUB && rnd == 5'd31) state_nxt = READY;
            READY: begin
                // A pending key beat takes priority over data.
                key_ready = 1'b1;
                din_ready = key_ok && !key_valid;
                if (key_valid)      state_nxt = (NB == 1) ? KEXP : KLOAD;
                else if (din_valid) state_nxt = (NB == 1) ? ROUND : DLOAD;
            end
            DLOAD: begin
                din_ready = 1'b1;
                if (din_valid && last_beat) state_nxt = ROUND;
            end
            ROUND: if (fin) state_nxt = UNLOAD;
            UNLOAD: begin
                dout_valid = 1'b1;
                if (dout_ready && last_beat) state_nxt = READY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk    <= '0;
            tau    <= '0;
            beat   <= '0;
            rnd    <= '0;
            sub    <= '0;
            fin    <= 1'b0;
            dec    <= 1'b0;
            key_ok <= 1'b0;
        end else if (key_fire) begin
            beat   <= beat_nxt;
            blk    <= last_beat ? ((blk_sh | 128'(key_in)) ^ FK) : (blk_sh | 128'(key_in));
            key_ok <= 1'b0;
            rnd    <= '0;
            sub    <= '0;
        end else if (din_fire) begin
            beat <= beat_nxt;
            blk  <= blk_sh | 128'(din);
            if (state == READY) dec <= mode;
            rnd  <= '0;
            sub  <= '0;
            fin  <= 1'b0;
        end else if (dout_fire) begin
            beat <= beat_nxt;
            blk  <= blk_sh;
        end else if (state == KEXP || state == ROUND) begin
            if (fin) begin
                blk <= {x3, x2, x1, x0};
                fin <= 1'b0;
            end else if (sub == UPD_SUB) begin
                blk <= {x1, x2, x3, x0 ^ lin};
                sub <= '0;
                rnd <= rnd + 5'd1;
                if (rnd == 5'd31) begin
                    if (state == KEXP) key_ok <= 1'b1;
                    else               fin    <= 1'b1;
                end
            end else begin
                for (int l = 0; l < SBOX_PAR; l++)
                    tau[8*(3 - (int'(lane_base) + l)) +: 8] <= lane_out[l];
                sub <= sub + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == KEXP && sub == UPD_SUB) rk[rnd] <= x0 ^ lin;
    end
endmodule
